// File: rtl/alu_op_sequencer.sv
// ---------------------------------------------------------------------------
// alu_op_sequencer
//
// Accepts one ALU request at a time, drives an external ALU with a one-hot
// control word and the latched operands for N cycles (N = MULDIV_WAIT for
// multiply/divide, 1 otherwise), captures the ALU result into zhi/zlo and
// presents a response that is held until the consumer takes it. Opcodes
// 12..15 are rejected with an error response and no ALU activity.
//
// Ports
//   clock       : single clock, rising edge
//   clear       : asynchronous active-low reset
//   req_valid   : request present            req_ready : block is IDLE
//   req_op      : opcode (0..11 legal)       req_a/b   : operands
//   alu_ctrl    : one-hot ALU select (EXEC only, else 0)
//   alu_x/alu_y : ALU operands (EXEC only, else 0)
//   alu_result  : ALU output {hi, lo}
//   rsp_valid   : response present           rsp_ready : consumer accepts
//   rsp_err     : response is an illegal-op error
//   zhi/zlo     : captured result halves
//   busy        : high in every state except IDLE
// ---------------------------------------------------------------------------
module alu_op_sequencer #(
    parameter int BITS        = 32,
    parameter int SIG_COUNT   = 12,
    parameter int MULDIV_WAIT = 4
) (
    input  logic                   clock,
    input  logic                   clear,
    input  logic                   req_valid,
    output logic                   req_ready,
    input  logic [3:0]             req_op,
    input  logic [BITS-1:0]        req_a,
    input  logic [BITS-1:0]        req_b,
    output logic [SIG_COUNT-1:0]   alu_ctrl,
    output logic [BITS-1:0]        alu_x,
    output logic [BITS-1:0]        alu_y,
    input  logic [2*BITS-1:0]      alu_result,
    output logic                   rsp_valid,
    input  logic                   rsp_ready,
    output logic                   rsp_err,
    output logic [BITS-1:0]        zhi,
    output logic [BITS-1:0]        zlo,
    output logic                   busy
);

    localparam logic [3:0] OP_MUL        = 4'd2;
    localparam logic [3:0] OP_DIV        = 4'd3;
    localparam logic [3:0] OP_LAST_LEGAL = 4'd11;
    // Counter preload for mul/div: EXEC lasts MULDIV_WAIT cycles, counting down to 0.
    localparam logic [3:0] CNT_MULDIV    = 4'(MULDIV_WAIT - 1);

    typedef enum logic [1:0] {IDLE, EXEC, DONE, ERR} state_t;

    state_t            state;
    state_t            state_nxt;
    logic [3:0]        cnt;
    logic [3:0]        op_q;
    logic [BITS-1:0]   a_q;
    logic [BITS-1:0]   b_q;

    logic accept;
    logic req_legal;
    logic req_muldiv;
    logic op_q_muldiv;
    logic exec_last;

    assign accept      = req_valid && (state == IDLE);
    assign req_legal   = (req_op <= OP_LAST_LEGAL);
    assign req_muldiv  = (req_op == OP_MUL) || (req_op == OP_DIV);
    assign op_q_muldiv = (op_q == OP_MUL) || (op_q == OP_DIV);
    assign exec_last   = (state == EXEC) && (cnt == 4'd0);

    // State register
    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (req_valid) begin
                    state_nxt = req_legal ? EXEC : ERR;
                end
            end
            EXEC: begin
                if (cnt == 4'd0) begin
                    state_nxt = DONE;
                end
            end
            DONE, ERR: begin
                // A handshake returns to IDLE; a new request can only be
                // taken on the following edge.
                if (rsp_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Operand latch, cycle counter and result capture
    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            cnt  <= 4'd0;
            op_q <= 4'd0;
            a_q  <= '0;
            b_q  <= '0;
            zhi  <= '0;
            zlo  <= '0;
        end else if (accept) begin
            op_q <= req_op;
            a_q  <= req_a;
            b_q  <= req_b;
            cnt  <= (req_legal && req_muldiv) ? CNT_MULDIV : 4'd0;
        end else if (state == EXEC) begin
            if (cnt != 4'd0) begin
                cnt <= cnt - 4'd1;
            end
            if (exec_last) begin
                zlo <= alu_result[BITS-1:0];
                // Only mul/div drive the upper ALU half.
                if (op_q_muldiv) begin
                    zhi <= alu_result[2*BITS-1:BITS];
                end
            end
        end
    end

    // Output decode
    always_comb begin
        req_ready = 1'b0;
        rsp_valid = 1'b0;
        rsp_err   = 1'b0;
        busy      = 1'b1;
        alu_ctrl  = '0;
        alu_x     = '0;
        alu_y     = '0;
        case (state)
            IDLE: begin
                req_ready = 1'b1;
                busy      = 1'b0;
            end
            EXEC: begin
                alu_ctrl = SIG_COUNT'(1) << op_q;
                alu_x    = a_q;
                alu_y    = b_q;
            end
            DONE: begin
                rsp_valid = 1'b1;
            end
            ERR: begin
                rsp_valid = 1'b1;
                rsp_err   = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// ---------------------------------------------------------------------------
// tb_alu_op_sequencer
//
// Directed bench for alu_op_sequencer with a behavioural ALU model. Latency
// is counted in rising edges with the acceptance edge as edge 1, so a
// single-cycle op shows rsp_valid after edge 2 and mul/div after edge
// 1+MULDIV_WAIT.
// ---------------------------------------------------------------------------
module tb_alu_op_sequencer;

    localparam int BITS        = 32;
    localparam int SIG_COUNT   = 12;
    localparam int MULDIV_WAIT = 4;

    logic                  clock;
    logic                  clear;
    logic                  req_valid;
    logic                  req_ready;
    logic [3:0]            req_op;
    logic [BITS-1:0]       req_a;
    logic [BITS-1:0]       req_b;
    logic [SIG_COUNT-1:0]  alu_ctrl;
    logic [BITS-1:0]       alu_x;
    logic [BITS-1:0]       alu_y;
    logic [2*BITS-1:0]     alu_result;
    logic                  rsp_valid;
    logic                  rsp_ready;
    logic                  rsp_err;
    logic [BITS-1:0]       zhi;
    logic [BITS-1:0]       zlo;
    logic                  busy;

    int n_cmp = 0;
    int n_bad = 0;

    alu_op_sequencer #(
        .BITS        (BITS),
        .SIG_COUNT   (SIG_COUNT),
        .MULDIV_WAIT (MULDIV_WAIT)
    ) dut (
        .clock      (clock),
        .clear      (clear),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_op     (req_op),
        .req_a      (req_a),
        .req_b      (req_b),
        .alu_ctrl   (alu_ctrl),
        .alu_x      (alu_x),
        .alu_y      (alu_y),
        .alu_result (alu_result),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_err    (rsp_err),
        .zhi        (zhi),
        .zlo        (zlo),
        .busy       (busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Behavioural ALU. The upper half carries junk for non mul/div ops and
    // the whole bus carries junk when no op is selected.
    localparam logic [BITS-1:0] JUNK_HI = 32'hDEADBEEF;
    localparam logic [BITS-1:0] JUNK_LO = 32'hCAFEF00D;
    always_comb begin
        alu_result = {JUNK_HI, JUNK_LO};
        case (alu_ctrl)
            12'h001: alu_result = {JUNK_HI, alu_x + alu_y};
            12'h002: alu_result = {JUNK_HI, alu_x - alu_y};
            12'h004: alu_result = 64'(alu_x) * 64'(alu_y);
            12'h008: alu_result = (alu_y == '0) ? '1 : {alu_x % alu_y, alu_x / alu_y};
            12'h010: alu_result = {JUNK_HI, alu_x << alu_y[4:0]};
            12'h020: alu_result = {JUNK_HI, alu_x >> alu_y[4:0]};
            12'h040: alu_result = {JUNK_HI, alu_x & alu_y};
            12'h080: alu_result = {JUNK_HI, alu_x | alu_y};
            12'h100: alu_result = {JUNK_HI, alu_x ^ alu_y};
            12'h200, 12'h400, 12'h800: alu_result = {JUNK_HI, alu_x};
            default: ;
        endcase
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [3:0]           op;
        logic [BITS-1:0]      a;
        logic [BITS-1:0]      b;
        logic [SIG_COUNT-1:0] ctrl;
        logic [BITS-1:0]      exp_zlo;
        logic [BITS-1:0]      exp_zhi;
        logic                 err;
        int                   lat;
    } vec_t;

    // Issue one request, measure latency, check EXEC drive and the response,
    // then complete the handshake.
    task automatic run_vec(input vec_t v, input int idx);
        int   edges;
        int   exec_n;
        logic drive_ok;
        @(negedge clock);
        check($sformatf("v%0d req_ready_idle", idx), req_ready, 1);
        req_valid = 1'b1;
        req_op    = v.op;
        req_a     = v.a;
        req_b     = v.b;
        rsp_ready = 1'b0;
        @(posedge clock);
        edges    = 1;
        exec_n   = 0;
        drive_ok = 1'b1;
        @(negedge clock);
        // Garbage on the request bus must not disturb the operation.
        req_valid = 1'b0;
        req_op    = 4'($urandom);
        req_a     = $urandom;
        req_b     = $urandom;
        while (!rsp_valid && edges < 40) begin
            if (alu_ctrl !== v.ctrl || alu_x !== v.a || alu_y !== v.b || req_ready !== 1'b0)
                drive_ok = 1'b0;
            exec_n++;
            @(posedge clock);
            edges++;
            @(negedge clock);
        end
        check($sformatf("v%0d latency_edges", idx), edges, v.lat);
        check($sformatf("v%0d exec_cycles", idx), exec_n, v.err ? 0 : v.lat - 1);
        check($sformatf("v%0d exec_drive", idx), drive_ok, 1);
        check($sformatf("v%0d rsp_err", idx), rsp_err, v.err);
        check($sformatf("v%0d zlo", idx), zlo, v.exp_zlo);
        check($sformatf("v%0d zhi", idx), zhi, v.exp_zhi);
        check($sformatf("v%0d ctrl_idle_in_rsp", idx), {alu_ctrl, alu_x, alu_y}, 0);
        check($sformatf("v%0d busy_in_rsp", idx), busy, 1);
        rsp_ready = 1'b1;
        @(posedge clock);
        @(negedge clock);
        rsp_ready = 1'b0;
        check($sformatf("v%0d after_handshake", idx), {rsp_valid, req_ready, busy}, 3'b010);
    endtask

    vec_t vecs[10];
    vec_t add11;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int   waited;
        logic stayed;

        vecs[0] = '{4'd0,  32'd5,         32'd7,         12'h001, 32'd12,        32'd0,         1'b0, 2};
        vecs[1] = '{4'd2,  32'h00010000,  32'h00010000,  12'h004, 32'h00000000,  32'h00000001,  1'b0, 5};
        vecs[2] = '{4'd13, 32'd9,         32'd9,         12'h000, 32'h00000000,  32'h00000001,  1'b1, 1};
        vecs[3] = '{4'd0,  32'hFFFFFFFF,  32'd2,         12'h001, 32'd1,         32'h00000001,  1'b0, 2};
        vecs[4] = '{4'd3,  32'd100,       32'd7,         12'h008, 32'd14,        32'd2,         1'b0, 5};
        vecs[5] = '{4'd4,  32'd1,         32'd31,        12'h010, 32'h80000000,  32'd2,         1'b0, 2};
        vecs[6] = '{4'd11, 32'h1234,      32'h5678,      12'h800, 32'h1234,      32'd2,         1'b0, 2};
        vecs[7] = '{4'd12, 32'h1,         32'h1,         12'h000, 32'h1234,      32'd2,         1'b1, 1};
        vecs[8] = '{4'd2,  32'hFFFFFFFF,  32'hFFFFFFFF,  12'h004, 32'h00000001,  32'hFFFFFFFE,  1'b0, 5};
        vecs[9] = '{4'd15, 32'h7,         32'h7,         12'h000, 32'h00000001,  32'hFFFFFFFE,  1'b1, 1};
        add11   = '{4'd0,  32'd1,         32'd1,         12'h001, 32'd2,         32'd0,         1'b0, 2};

        clear     = 1'b0;
        req_valid = 1'b0;
        req_op    = 4'd0;
        req_a     = '0;
        req_b     = '0;
        rsp_ready = 1'b0;

        // Reset state
        repeat (3) @(negedge clock);
        check("reset_outputs", {rsp_valid, rsp_err, busy, alu_ctrl, alu_x, alu_y, zhi, zlo}, 0);
        clear = 1'b1;
        @(negedge clock);
        check("reset_release_ready", {req_ready, busy}, 2'b10);

        for (int i = 0; i < 10; i++) begin
            run_vec(vecs[i], i);
        end

        // Backpressure: sub 3-10 held for 6 cycles, a competing request ignored.
        @(negedge clock);
        req_valid = 1'b1; req_op = 4'd1; req_a = 32'd3; req_b = 32'd10;
        @(posedge clock);
        @(negedge clock);
        req_valid = 1'b0;
        waited = 0;
        while (!rsp_valid && waited < 10) begin
            @(posedge clock);
            @(negedge clock);
            waited++;
        end
        check("bp_rsp_seen", rsp_valid, 1);
        req_valid = 1'b1; req_op = 4'd0; req_a = 32'd1; req_b = 32'd1;
        for (int c = 0; c < 6; c++) begin
            check($sformatf("bp_hold_c%0d", c), {rsp_valid, rsp_err, req_ready, busy, zlo, zhi},
                  {1'b1, 1'b0, 1'b0, 1'b1, 32'hFFFFFFF9, 32'hFFFFFFFE});
            @(posedge clock);
            @(negedge clock);
        end
        rsp_ready = 1'b1;
        @(posedge clock);
        @(negedge clock);
        // Still IDLE: the request was not taken on the handshake edge.
        check("bp_no_accept_on_handshake", {req_ready, busy, rsp_valid}, 3'b100);
        check("bp_zlo_kept", zlo, 32'hFFFFFFF9);
        req_valid = 1'b0;
        rsp_ready = 1'b0;

        // Reset during the 2nd EXEC cycle of a divide.
        @(negedge clock);
        req_valid = 1'b1; req_op = 4'd3; req_a = 32'd100; req_b = 32'd7;
        @(posedge clock);
        @(negedge clock);
        req_valid = 1'b0;
        check("rst_exec1_ctrl", alu_ctrl, 12'h008);
        @(posedge clock);
        @(negedge clock);
        check("rst_exec2_ctrl", alu_ctrl, 12'h008);
        clear = 1'b0;
        #1;
        check("rst_async_outputs", {rsp_valid, rsp_err, busy, alu_ctrl, alu_x, alu_y, zhi, zlo}, 0);
        repeat (2) @(negedge clock);
        clear = 1'b1;
        rsp_ready = 1'b0;
        stayed = 1'b1;
        for (int c = 0; c < 8; c++) begin
            @(negedge clock);
            if (rsp_valid !== 1'b0 || busy !== 1'b0 || zlo !== '0 || zhi !== '0) stayed = 1'b0;
        end
        check("rst_no_response_after_release", stayed, 1);
        run_vec(add11, 10);

        // Back-to-back: add 2+3 then shl 3<<2 with rsp_ready held high.
        @(negedge clock);
        req_valid = 1'b1; req_op = 4'd0; req_a = 32'd2; req_b = 32'd3;
        rsp_ready = 1'b1;
        @(posedge clock);
        @(negedge clock);
        req_op = 4'd4; req_a = 32'd3; req_b = 32'd2;
        waited = 0;
        while (!rsp_valid && waited < 10) begin
            @(posedge clock);
            @(negedge clock);
            waited++;
        end
        check("b2b_first_zlo", {rsp_valid, zlo}, {1'b1, 32'd5});
        @(posedge clock);
        @(negedge clock);
        check("b2b_idle_after_handshake", {req_ready, busy, rsp_valid}, 3'b100);
        @(posedge clock);
        @(negedge clock);
        req_valid = 1'b0;
        check("b2b_second_accepted", {busy, alu_ctrl, alu_x, alu_y}, {1'b1, 12'h010, 32'd3, 32'd2});
        waited = 0;
        while (!rsp_valid && waited < 10) begin
            @(posedge clock);
            @(negedge clock);
            waited++;
        end
        check("b2b_second_zlo", {rsp_valid, rsp_err, zlo, zhi}, {1'b1, 1'b0, 32'd12, 32'd0});
        @(posedge clock);
        @(negedge clock);
        rsp_ready = 1'b0;
        check("b2b_final_idle", {req_ready, busy}, 2'b10);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/alu_op_sequencer.md
ALU_OP_SEQUENCER -- requirements
Module: alu_op_sequencer

Interface
REQ-001 The block SHALL have parameter BITS, default 32, operand and Z-half width.
REQ-002 The block SHALL have parameter SIG_COUNT, default 12, width of the one-hot ALU control.
REQ-003 The block SHALL have parameter MULDIV_WAIT, default 4, EXEC cycles for multiply and divide (legal range 1..15).
REQ-004 The block SHALL have the port clock, input, 1 bit, the single clock; all state changes on its rising edge.
REQ-005 The block SHALL have the port clear, input, 1 bit, an asynchronous active-low reset.
REQ-006 The block SHALL have the ports req_valid (input, 1), req_ready (output, 1), req_op (input, 4) and req_a / req_b (inputs, BITS), forming the request channel.
REQ-007 The block SHALL have the ports alu_ctrl (output, SIG_COUNT), alu_x / alu_y (outputs, BITS) and alu_result (input, 2*BITS), which drive and read the ALU.
REQ-008 The block SHALL have the ports rsp_valid (output, 1), rsp_ready (input, 1) and rsp_err (output, 1), forming the response channel.
REQ-009 The block SHALL have the ports zhi and zlo (outputs, BITS each), the captured result registers.
REQ-010 The block SHALL have the port busy (output, 1), high in every state except IDLE.

Function
REQ-011 The block SHALL implement exactly four states: IDLE, EXEC, DONE and ERR.
REQ-012 The block SHALL drive req_ready high only in IDLE; a request is accepted on an edge where req_valid=1 and req_ready=1.
REQ-013 On acceptance, the block SHALL latch req_op, req_a and req_b into internal registers.
REQ-014 On acceptance, if req_op<=11 the block SHALL enter EXEC with its counter set to N-1, where N=MULDIV_WAIT for op 2 (mul) or op 3 (div) and N=1 for all other ops.
REQ-015 On acceptance, if req_op>=12 the block SHALL enter ERR with no ALU activity.
REQ-016 In EXEC, the block SHALL drive alu_ctrl as one-hot with bit[op]=1, alu_x=latched a and alu_y=latched b; these values stay stable for the whole of EXEC.
REQ-017 Outside EXEC, the block SHALL drive alu_ctrl=0, alu_x=0 and alu_y=0.
REQ-018 On each EXEC edge with counter≠0, the block SHALL decrement the counter.
REQ-019 On the EXEC edge with counter=0, the block SHALL load zlo<=alu_result[BITS-1:0].
REQ-020 On that same edge, for op 2 or 3 only, the block SHALL load zhi<=alu_result[2*BITS-1:BITS]; for all other ops zhi keeps its value (the upper ALU half is not driven for those ops).
REQ-021 On that same edge, the block SHALL move to DONE.
REQ-022 Latency: rsp_valid SHALL rise 1+N edges after the acceptance edge (2 edges for single-cycle ops, 1+MULDIV_WAIT edges for mul/div).
REQ-023 In DONE, the block SHALL hold rsp_valid=1 and rsp_err=0.
REQ-024 In ERR, the block SHALL hold rsp_valid=1 and rsp_err=1, with zhi and zlo unchanged.
REQ-025 From DONE or ERR, on an edge with rsp_ready=1 the block SHALL return to IDLE; with rsp_ready=0 it SHALL hold its state and all outputs indefinitely.
REQ-026 Back-to-back: after a response handshake, req_ready SHALL rise in the next cycle; no request is accepted on the same edge as a response handshake.
REQ-027 The block SHALL ignore req_valid, req_op, req_a and req_b in all states other than IDLE.
REQ-028 The block SHALL ignore rsp_ready in IDLE and EXEC.

Reset
REQ-029 When clear is low, the block SHALL immediately (asynchronously) enter IDLE and drive zhi=0, zlo=0, rsp_valid=0, rsp_err=0, busy=0, alu_ctrl=0, alu_x=0, alu_y=0, counter=0 and all latched operands 0; req_ready=1 once clear is high.
REQ-030 If clear asserts mid-EXEC or in DONE/ERR, the block SHALL abandon the operation, capture no result and produce no response after reset is released.

Verification
REQ-031 The bench SHALL cover add: op 0, a=5, b=7 -> alu_ctrl=0x001 for 1 cycle, zlo=12, zhi unchanged, rsp_valid 2 edges after acceptance, rsp_err=0.
REQ-032 The bench SHALL cover mul: op 2, a=0x00010000, b=0x00010000, MULDIV_WAIT=4 -> alu_ctrl=0x004 held 4 cycles, zhi=0x00000001, zlo=0x00000000, rsp_valid 5 edges after acceptance.
REQ-033 The bench SHALL cover an illegal op: op 13 -> ERR, rsp_err=1, alu_ctrl stays 0, zhi and zlo unchanged from the prior operation.
REQ-034 The bench SHALL cover backpressure: sub op 1, a=3, b=10 with rsp_ready=0 for 6 cycles -> rsp_valid and zlo=0xFFFFFFF9 stable all 6 cycles, req_ready=0 throughout, and a new req_valid is ignored.
REQ-035 The bench SHALL cover reset mid-operation: clear low during the 2nd EXEC cycle of a div -> all outputs 0 immediately, no rsp_valid after release, and the next add (1+1) gives zlo=2.
REQ-036 The bench SHALL cover back-to-back operations: add then shift-left with rsp_ready=1 constantly -> the second request is accepted exactly 1 cycle after the first response handshake.
